// File: rtl/panel_write_queue_pkg.sv
// panel_pkg: shared constants, the queued-entry layout and the colour
// expansion helper for the panel write queue.
//   PANEL_COUNT    - number of panel write enables
//   COLOR_BITS     - bits per incoming colour channel
//   DEFAULT_ADDR_W - default framebuffer address width
//   pix_write_t    - one queued pixel write at the default address width
//   expand6to8     - 6-bit to 8-bit channel expansion by MSB replication
package panel_pkg;

  localparam int PANEL_COUNT    = 6;
  localparam int COLOR_BITS     = 6;
  localparam int DEFAULT_ADDR_W = 14;

  // Field order matches the packing used by panel_write_queue for any ADDR_W.
  typedef struct packed {
    logic [PANEL_COUNT-1:0]    en;
    logic [2:0]                wr;
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [COLOR_BITS-1:0]     r;
    logic [COLOR_BITS-1:0]     g;
    logic [COLOR_BITS-1:0]     b;
  } pix_write_t;

  // Replicating the top two bits maps full scale to full scale (3F -> FF).
  function automatic logic [7:0] expand6to8(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/panel_write_queue_if.sv
// panel_write_queue_if: groups the upstream write strobe and the framebuffer
// write port of the panel write queue.
//   ctrl_en/ctrl_wr/ctrl_addr/ctrl_wdat - single-cycle write strobe from the writer
//   fb_we/fb_be/fb_addr/fb_wdat         - framebuffer write presented by the queue
//   fb_ready                            - framebuffer accepts the presented write
// Modports: master = upstream writer plus framebuffer, slave = the queue.
interface panel_write_queue_if
  import panel_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic [PANEL_COUNT-1:0] ctrl_en;
  logic [3:0]             ctrl_wr;
  logic [15:0]            ctrl_addr;
  logic [23:0]            ctrl_wdat;

  logic [PANEL_COUNT-1:0] fb_we;
  logic [2:0]             fb_be;
  logic [ADDR_W-1:0]      fb_addr;
  logic [23:0]            fb_wdat;
  logic                   fb_ready;

  modport master (
    output ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat, fb_ready,
    input  fb_we, fb_be, fb_addr, fb_wdat
  );

  modport slave (
    input  ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat, fb_ready,
    output fb_we, fb_be, fb_addr, fb_wdat
  );

endinterface

// File: rtl/panel_write_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO with flop storage read through a registered
// pointer, so the head entry is available in the same cycle it is popped.
//   clock, reset_n - clock and asynchronous active-low reset
//   clear          - synchronous drop of all entries
//   push, wr_data  - write request (taken when not full, or when popping)
//   pop, rd_data   - consume the head entry (ignored when empty)
//   full, empty    - occupancy flags
//   level          - registered occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] PTR_ZERO = {(PTR_W + 1){1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic [PTR_W:0]   level_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_en_s;
  logic             rd_en_s;

  // Flags from the lap bit; a write on a full FIFO is allowed when the head leaves.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
              (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    rd_en_s = pop & ~empty_s & ~clear;
    wr_en_s = push & (~full_s | rd_en_s) & ~clear;
  end

  // Entry storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= wr_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= PTR_ZERO;
    end else if (clear) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= PTR_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   level_r <= level_r + PTR_ONE;
        2'b01:   level_r <= level_r - PTR_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r[PTR_W-1:0]];
  assign full    = full_s;
  assign empty   = empty_s;
  assign level   = level_r;

endmodule

// File: rtl/panel_write_queue.sv
// panel_write_queue: absorbs the panel writer's unthrottled pixel strobes in
// a FIFO and replays them to the framebuffer under valid/ready, expanding
// 6-bit channels to 8 bits and counting strobes lost to a full FIFO.
//   clock, reset_n - clock and asynchronous active-low reset
//   bus (slave)    - ctrl_* strobe in, fb_* write out, fb_ready in
//   flush          - synchronous discard of queued and presented writes
//   fifo_level     - FIFO occupancy, not counting the presented write
//   drop_count     - saturating count of dropped strobes
//   busy           - anything queued or presented
module panel_write_queue
  import panel_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  panel_write_queue_if.slave     bus,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            drop_count,
  output logic                   busy
);

  typedef struct packed {
    logic [PANEL_COUNT-1:0] en;
    logic [2:0]             wr;
    logic [ADDR_W-1:0]      addr;
    logic [COLOR_BITS-1:0]  r;
    logic [COLOR_BITS-1:0]  g;
    logic [COLOR_BITS-1:0]  b;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t                 push_entry_s;
  entry_t                 head_entry_s;
  logic [ENTRY_W-1:0]     head_vec_s;
  logic                   push_req_s;
  logic                   pop_s;
  logic                   drop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [$clog2(DEPTH):0] level_s;

  logic                   out_valid_r;
  logic [PANEL_COUNT-1:0] fb_we_r;
  logic [2:0]             fb_be_r;
  logic [ADDR_W-1:0]      fb_addr_r;
  logic [23:0]            fb_wdat_r;
  logic [15:0]            drop_count_r;
  logic                   unused_s;

  // Strobe qualification, head consumption and drop detection.
  always_comb begin
    push_entry_s.en   = bus.ctrl_en;
    push_entry_s.wr   = bus.ctrl_wr[2:0];
    push_entry_s.addr = bus.ctrl_addr[ADDR_W-1:0];
    push_entry_s.r    = bus.ctrl_wdat[21:16];
    push_entry_s.g    = bus.ctrl_wdat[13:8];
    push_entry_s.b    = bus.ctrl_wdat[5:0];
    head_entry_s      = entry_t'(head_vec_s);
    // An empty channel mask makes the strobe a no-op rather than a write.
    push_req_s = (|bus.ctrl_en) & (|bus.ctrl_wr[2:0]) & ~flush;
    pop_s      = ~fifo_empty_s & (~out_valid_r | bus.fb_ready) & ~flush;
    // A pop in the same cycle frees the slot, so only a stuck full FIFO drops.
    drop_s     = push_req_s & fifo_full_s & ~pop_s;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (push_req_s),
    .pop     (pop_s),
    .wr_data (push_entry_s),
    .rd_data (head_vec_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (level_s)
  );

  // Output register: loads the head, retires on ready, holds data while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      fb_we_r     <= {PANEL_COUNT{1'b0}};
      fb_be_r     <= 3'b000;
      fb_addr_r   <= {ADDR_W{1'b0}};
      fb_wdat_r   <= 24'h000000;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      fb_we_r     <= {PANEL_COUNT{1'b0}};
    end else if (pop_s) begin
      out_valid_r <= 1'b1;
      fb_we_r     <= head_entry_s.en;
      fb_be_r     <= head_entry_s.wr;
      fb_addr_r   <= head_entry_s.addr;
      fb_wdat_r   <= {expand6to8(head_entry_s.r),
                      expand6to8(head_entry_s.g),
                      expand6to8(head_entry_s.b)};
    end else if (out_valid_r && bus.fb_ready) begin
      out_valid_r <= 1'b0;
      fb_we_r     <= {PANEL_COUNT{1'b0}};
    end
  end

  // Saturating drop counter; flush leaves it alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count_r <= 16'h0000;
    end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
      drop_count_r <= drop_count_r + 16'h0001;
    end
  end

  // Ignored strobe bits are folded here so they are visibly consumed.
  assign unused_s = ^{bus.ctrl_wr[3], bus.ctrl_addr, bus.ctrl_wdat};

  assign bus.fb_we   = fb_we_r;
  assign bus.fb_be   = fb_be_r;
  assign bus.fb_addr = fb_addr_r;
  assign bus.fb_wdat = fb_wdat_r;
  assign fifo_level  = level_s;
  assign drop_count  = drop_count_r;
  assign busy        = ~fifo_empty_s | out_valid_r;

endmodule

// File: tb/tb_panel_write_queue.sv
// Directed bench for panel_write_queue: a queue-level model of the block is
// compared against the DUT every cycle, plus literal expectations for the
// single-write, backpressure, overflow, boundary, flush and reset scenarios.
module tb_panel_write_queue;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 14;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush   = 1'b0;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count;
  logic        busy;

  panel_write_queue_if #(.ADDR_W(ADDR_W)) bus ();

  panel_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .flush      (flush),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0]  en;
    logic [2:0]  wr;
    logic [13:0] addr;
    logic [5:0]  r;
    logic [5:0]  g;
    logic [5:0]  b;
  } ent_t;

  ent_t        fq[$];
  ent_t        out_e;
  bit          out_v = 1'b0;
  int          drops = 0;
  logic [13:0] deliv[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] x8(input logic [5:0] c);
    int v;
    v = int'(c) * 4 + int'(c) / 16;
    return v[7:0];
  endfunction

  task automatic model_reset();
    fq.delete();
    out_v = 1'b0;
    drops = 0;
  endtask

  task automatic model_step();
    bit   req;
    bit   pop;
    bit   was_full;
    ent_t e;
    if (flush) begin
      fq.delete();
      out_v = 1'b0;
    end else begin
      req      = (bus.ctrl_en != 6'd0) && (bus.ctrl_wr[2:0] != 3'd0);
      was_full = (fq.size() == DEPTH);
      if (out_v && bus.fb_ready) deliv.push_back(out_e.addr);
      pop = (fq.size() != 0) && (!out_v || bus.fb_ready);
      if (pop) begin
        out_e = fq.pop_front();
        out_v = 1'b1;
      end else if (out_v && bus.fb_ready) begin
        out_v = 1'b0;
      end
      if (req) begin
        if (!was_full || pop) begin
          e.en   = bus.ctrl_en;
          e.wr   = bus.ctrl_wr[2:0];
          e.addr = bus.ctrl_addr[13:0];
          e.r    = bus.ctrl_wdat[21:16];
          e.g    = bus.ctrl_wdat[13:8];
          e.b    = bus.ctrl_wdat[5:0];
          fq.push_back(e);
        end else if (drops < 65535) begin
          drops++;
        end
      end
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  task automatic compare_now();
    logic [5:0] exp_we;
    exp_we = out_v ? out_e.en : 6'd0;
    check("fb_we", 32'(bus.fb_we), 32'(exp_we));
    if (out_v) begin
      check("fb_be", 32'(bus.fb_be), 32'(out_e.wr));
      check("fb_addr", 32'(bus.fb_addr), 32'(out_e.addr));
      check("fb_wdat", 32'(bus.fb_wdat), {8'h00, x8(out_e.r), x8(out_e.g), x8(out_e.b)});
    end
    if (!reset_n) begin
      check("rst_be", 32'(bus.fb_be), 32'd0);
      check("rst_addr", 32'(bus.fb_addr), 32'd0);
      check("rst_wdat", 32'(bus.fb_wdat), 32'd0);
    end
    check("fifo_level", 32'(fifo_level), 32'(fq.size()));
    check("drop_count", 32'(drop_count), 32'(drops));
    check("busy", 32'(busy), 32'((fq.size() != 0) || out_v));
  endtask

  always @(negedge clock) compare_now();

  task automatic cyc(input logic [5:0] en, input logic [3:0] wr, input logic [15:0] addr,
                     input logic [23:0] wdat, input logic rdy, input logic fl);
    @(posedge clock);
    #1;
    bus.ctrl_en   = en;
    bus.ctrl_wr   = wr;
    bus.ctrl_addr = addr;
    bus.ctrl_wdat = wdat;
    bus.fb_ready  = rdy;
    flush         = fl;
  endtask

  task automatic idle(input logic rdy);
    cyc(6'd0, 4'd0, 16'h0000, 24'h000000, rdy, 1'b0);
  endtask

  initial begin
    bus.ctrl_en   = 6'd0;
    bus.ctrl_wr   = 4'd0;
    bus.ctrl_addr = 16'h0000;
    bus.ctrl_wdat = 24'h000000;
    bus.fb_ready  = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;

    // Single write: R=3F G=20 B=01
    cyc(6'b000100, 4'b0111, 16'h1234, 24'h3F2001, 1'b1, 1'b0);
    idle(1'b1);
    check("single_lat1_we", 32'(bus.fb_we), 32'h00);
    idle(1'b1);
    check("single_we", 32'(bus.fb_we), 32'h04);
    check("single_addr", 32'(bus.fb_addr), 32'h1234);
    check("single_wdat", 32'(bus.fb_wdat), 32'hFF8204);
    check("single_be", 32'(bus.fb_be), 32'h7);
    idle(1'b1);
    check("single_done_we", 32'(bus.fb_we), 32'h00);
    check("single_done_busy", 32'(busy), 32'h0);

    // Backpressure: five writes held, then released
    deliv.delete();
    for (int i = 0; i < 5; i++)
      cyc(6'(6'b000001 << i), 4'(i + 1), 16'(16'h0200 + i), 24'(24'h0A0B0C + i), 1'b0, 1'b0);
    idle(1'b0);
    check("bp_level", 32'(fifo_level), 32'd4);
    check("bp_model_level", 32'(fq.size()), 32'd4);
    check("bp_head_addr", 32'(bus.fb_addr), 32'h0200);
    check("bp_head_we", 32'(bus.fb_we), 32'h01);
    repeat (2) idle(1'b0);
    repeat (7) idle(1'b1);
    check("bp_count", 32'(deliv.size()), 32'd5);
    for (int i = 0; i < 5 && i < deliv.size(); i++)
      check("bp_order", 32'(deliv[i]), 32'(32'h0200 + i));

    // Overflow: DEPTH+3 strobes with no ready
    deliv.delete();
    for (int i = 0; i < DEPTH + 3; i++)
      cyc(6'b100000, 4'b0010, 16'(16'h0100 + i), 24'(24'h001500 + i), 1'b0, 1'b0);
    idle(1'b0);
    check("ovf_drop", 32'(drop_count), 32'd2);
    check("ovf_model_drop", 32'(drops), 32'd2);
    check("ovf_level", 32'(fifo_level), 32'd16);
    // Push on full with a simultaneous pop; upper address and data bits ignored
    cyc(6'b000010, 4'b1100, 16'hC1FF, 24'hFFFFFF, 1'b1, 1'b0);
    idle(1'b0);
    check("fullpop_drop", 32'(drop_count), 32'd2);
    check("fullpop_level", 32'(fifo_level), 32'd16);
    // Channel mask empty apart from the ignored bit: no push
    cyc(6'b000001, 4'b1000, 16'h0333, 24'h123456, 1'b0, 1'b0);
    idle(1'b0);
    check("nomask_level", 32'(fifo_level), 32'd16);
    check("nomask_drop", 32'(drop_count), 32'd2);
    repeat (20) idle(1'b1);
    check("ovf_count", 32'(deliv.size()), 32'd18);
    for (int i = 0; i < 18 && i < deliv.size(); i++)
      check("ovf_order", 32'(deliv[i]), (i < 17) ? 32'(32'h0100 + i) : 32'h01FF);

    // Flush with six queued writes and a strobe on the flush cycle
    for (int i = 0; i < 6; i++)
      cyc(6'b001000, 4'b0001, 16'(16'h0300 + i), 24'h00003F, 1'b0, 1'b0);
    cyc(6'b111111, 4'b0111, 16'h03AA, 24'h3F3F3F, 1'b0, 1'b1);
    idle(1'b1);
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_level", 32'(fifo_level), 32'd0);
    check("flush_we", 32'(bus.fb_we), 32'h00);
    check("flush_drop", 32'(drop_count), 32'd2);
    repeat (4) idle(1'b1);
    check("flush_after_we", 32'(bus.fb_we), 32'h00);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 4; i++)
      cyc(6'b000001, 4'b0100, 16'(16'h0400 + i), 24'h200000, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("rst_we_now", 32'(bus.fb_we), 32'h00);
    check("rst_level_now", 32'(fifo_level), 32'd0);
    check("rst_drop_now", 32'(drop_count), 32'd0);
    check("rst_busy_now", 32'(busy), 32'h0);
    check("rst_addr_now", 32'(bus.fb_addr), 32'h0);
    check("rst_wdat_now", 32'(bus.fb_wdat), 32'h0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    cyc(6'b010000, 4'b0101, 16'h2ABC, 24'h203F00, 1'b1, 1'b0);
    idle(1'b1);
    check("post_rst_lat1_we", 32'(bus.fb_we), 32'h00);
    idle(1'b1);
    check("post_rst_we", 32'(bus.fb_we), 32'h10);
    check("post_rst_addr", 32'(bus.fb_addr), 32'h2ABC);
    check("post_rst_wdat", 32'(bus.fb_wdat), 32'h82FF00);
    check("post_rst_be", 32'(bus.fb_be), 32'h5);
    repeat (3) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
